// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Shared ALU constants and the Y86 condition-code helper.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int C_ALU_WIDTH = 64;

  // Y86 condition-code vector layout
  localparam int C_FLAG_W  = 3;
  localparam int C_FLAG_ZF = 2;
  localparam int C_FLAG_SF = 1;
  localparam int C_FLAG_OF = 0;

  typedef logic [C_FLAG_W-1:0] cc_t;

  // Overflow when both addends share a sign that the result does not.
  function automatic cc_t y86_cc(
    input logic i_zero,
    input logic i_sign,
    input logic i_a_sign,
    input logic i_b_sign
  );
    cc_t w_cc;
    w_cc            = '0;
    w_cc[C_FLAG_ZF] = i_zero;
    w_cc[C_FLAG_SF] = i_sign;
    w_cc[C_FLAG_OF] = (i_a_sign == i_b_sign) && (i_sign != i_a_sign);
    return w_cc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// ---------------------------------------------------------------------------
// Module : addsub_slice
// Brief  : W-bit adder slice with carry in and carry out.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
  assign o_s   = w_sum[W-1:0];
  assign o_co  = w_sum[W];

endmodule

`default_nettype wire

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// Module : addsub_pipe
// Brief  : Pipelined add/subtract, one slice of carry ripple per clock,
//          Y86 flags, valid/ready on both sides with a global stall.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = C_ALU_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  // WIDTH must be a multiple of STAGES.
  localparam int C_SLICE_W = WIDTH / STAGES;
  localparam int C_LAST    = STAGES - 1;

  logic                  w_adv;
  logic [WIDTH-1:0]      w_b_eff;
  cc_t                   w_cc;

  // Inputs seen by each stage's slice adder
  logic [WIDTH-1:0]      w_op_a    [STAGES];
  logic [WIDTH-1:0]      w_op_b    [STAGES];
  logic [WIDTH-1:0]      w_sum_in  [STAGES];
  logic [WIDTH-1:0]      w_sum_nxt [STAGES];
  logic [C_SLICE_W-1:0]  w_sl_s    [STAGES];
  logic [STAGES-1:0]     w_ci;
  logic [STAGES-1:0]     w_sl_co;
  logic [STAGES-1:0]     w_in_vld;
  logic [STAGES-1:0]     w_as_in;
  logic [STAGES-1:0]     w_bs_in;

  // Pipeline registers; r_a/r_b hold the unprocessed operand bits shifted down
  logic [STAGES-1:0]     r_vld;
  logic [STAGES-1:0]     r_cy;
  logic [WIDTH-1:0]      r_sum [STAGES];
  logic [WIDTH-1:0]      r_a   [STAGES];
  logic [WIDTH-1:0]      r_b   [STAGES];
  logic                  r_as  [STAGES];
  logic                  r_bs  [STAGES];
  cc_t                   r_cc;

  assign w_adv    = out_ready | ~r_vld[C_LAST];
  assign in_ready = w_adv;
  assign w_b_eff  = m ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_op_a[k]   = a;
      assign w_op_b[k]   = w_b_eff;
      assign w_ci[k]     = cin;
      assign w_sum_in[k] = '0;
      assign w_in_vld[k] = in_valid;
      assign w_as_in[k]  = a[WIDTH-1];
      assign w_bs_in[k]  = w_b_eff[WIDTH-1];
    end else begin : g_tail
      assign w_op_a[k]   = r_a[k-1];
      assign w_op_b[k]   = r_b[k-1];
      assign w_ci[k]     = r_cy[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_in_vld[k] = r_vld[k-1];
      assign w_as_in[k]  = r_as[k-1];
      assign w_bs_in[k]  = r_bs[k-1];
    end

    addsub_slice #(
      .W (C_SLICE_W)
    ) u_slice (
      .i_a  (w_op_a[k][C_SLICE_W-1:0]),
      .i_b  (w_op_b[k][C_SLICE_W-1:0]),
      .i_ci (w_ci[k]),
      .o_s  (w_sl_s[k]),
      .o_co (w_sl_co[k])
    );

    assign w_sum_nxt[k] = w_sum_in[k] | (WIDTH'(w_sl_s[k]) << (k * C_SLICE_W));
  end

  assign w_cc = y86_cc(w_sum_nxt[C_LAST] == '0, w_sum_nxt[C_LAST][WIDTH-1],
                       w_as_in[C_LAST], w_bs_in[C_LAST]);

  // Data only loads behind a valid beat so bubbles leave the outputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_as[k]  <= 1'b0;
        r_bs[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld <= w_in_vld;
      for (int k = 0; k < STAGES; k++) begin
        if (w_in_vld[k]) begin
          r_sum[k] <= w_sum_nxt[k];
          r_a[k]   <= w_op_a[k] >> C_SLICE_W;
          r_b[k]   <= w_op_b[k] >> C_SLICE_W;
          r_cy[k]  <= w_sl_co[k];
          r_as[k]  <= w_as_in[k];
          r_bs[k]  <= w_bs_in[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= '0;
    end else if (w_adv && w_in_vld[C_LAST]) begin
      r_cc <= w_cc;
    end
  end

  assign out_valid = r_vld[C_LAST];
  assign s         = r_sum[C_LAST];
  assign cout      = r_cy[C_LAST];
  assign zf        = r_cc[C_FLAG_ZF];
  assign sf        = r_cc[C_FLAG_SF];
  assign of        = r_cc[C_FLAG_OF];

endmodule

`default_nettype wire

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// Module : tb_addsub_pipe
// Brief  : Self-checking bench for addsub_pipe against a behavioural model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_addsub_pipe;

  localparam int W  = 64;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         zf;
    logic         sf;
    logic         of;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         m = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, zf, sf, of;
  logic [W-1:0] s;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ret = 0;
  res_t q[$];
  res_t exp_r;
  res_t held;
  logic hold_p = 1'b0;
  bit   done = 1'b0;

  addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .m         (m),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  always #5 clk = ~clk;

  // Reference: full-width arithmetic, flags straight from their definitions
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fm, input logic fc);
    logic [W:0]   full;
    logic [W-1:0] be;
    res_t         r;
    be     = fm ? ~fb : fb;
    full   = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, fc};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.zf   = (r.s == '0);
    r.sf   = r.s[W-1];
    r.of   = (fa[W-1] == be[W-1]) && (r.s[W-1] != fa[W-1]);
    return r;
  endfunction

  function automatic res_t cur();
    return {s, cout, zf, sf, of};
  endfunction

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got s=%h cout=%b zf=%b sf=%b of=%b, want s=%h cout=%b zf=%b sf=%b of=%b",
               name, act.s, act.cout, act.zf, act.sf, act.of,
               exp.s, exp.cout, exp.zf, exp.sf, exp.of);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, inputs change after rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_p = 1'b0;
      chk_bit("reset_out_valid", out_valid, 1'b0);
    end else begin
      chk_bit("in_ready_rule", in_ready, out_ready | ~out_valid);
      if (hold_p) begin
        chk_bit("hold_valid", out_valid, 1'b1);
        chk_res("hold_data", cur(), held);
      end
      hold_p = out_valid && !out_ready;
      held   = cur();
      if (out_valid && out_ready) begin
        n_ret++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got s=%h, want no result outstanding", s);
        end else begin
          exp_r = q.pop_front();
          chk_res("result", cur(), exp_r);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, m, cin));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tm, input logic tc);
    logic rdy;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    a = ta; b = tb; m = tm; cin = tc;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, want 1", n);
    end
  endtask

  // Single beat into an empty pipe: check latency and literal result
  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tm, input logic tc, input res_t exp);
    int n;
    out_ready = 1'b1;
    send(ta, tb, tm, tc);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk_int({name, "_latency"}, n, ST);
    chk_res(name, cur(), exp);
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    chk_int(name, q.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int   n;
    int   base;
    res_t bp_hold;

    #2;
    chk_bit("reset_valid", out_valid, 1'b0);
    chk_res("reset_outputs", cur(), '0);
    #10;
    rst_n = 1'b1;
    step();
    chk_bit("post_reset_in_ready", in_ready, 1'b1);

    directed("subtract", 64'd5, '1, 1'b1, 1'b1,
             '{s: 64'd6, cout: 1'b0, zf: 1'b0, sf: 1'b0, of: 1'b0});
    directed("overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             '{s: 64'h8000_0000_0000_0000, cout: 1'b0, zf: 1'b0, sf: 1'b1, of: 1'b1});
    directed("wrap_zero", '1, 64'd1, 1'b0, 1'b0,
             '{s: 64'd0, cout: 1'b1, zf: 1'b1, sf: 1'b0, of: 1'b0});
    directed("slice_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             '{s: 64'h0000_0001_0000_0000, cout: 1'b0, zf: 1'b0, sf: 1'b0, of: 1'b0});
    directed("neg_sub", 64'd3, 64'd10, 1'b1, 1'b1,
             '{s: 64'hFFFF_FFFF_FFFF_FFF9, cout: 1'b0, zf: 1'b0, sf: 1'b1, of: 1'b0});

    // Four back-to-back beats produce four back-to-back results
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(64'(i + 1) << 20, 64'h1234 * 64'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_bit("thru_valid", out_valid, i < 4);
      step();
    end

    // Backpressure: result held, offered beat blocked, nothing lost or duplicated
    base      = n_ret;
    out_ready = 1'b0;
    send(64'd100, 64'd23, 1'b0, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    bp_hold = cur();
    chk_res("bp_result", bp_hold, '{s: 64'd123, cout: 1'b0, zf: 1'b0, sf: 1'b0, of: 1'b0});
    in_valid = 1'b1;
    a = 64'd7; b = 64'd7; m = 1'b1; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_res("bp_stable", cur(), bp_hold);
      step();
    end
    out_ready = 1'b1;
    send(64'd7, 64'd7, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain("bp_drain");
    chk_int("bp_count", n_ret - base, 2);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(64'hABCD_0000 + 64'(i), 64'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("midrst_valid", out_valid, 1'b0);
    chk_res("midrst_outputs", cur(), '0);
    step();
    step();
    rst_n = 1'b1;
    chk_bit("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk_bit("midrst_no_ghost", out_valid, 1'b0);
      step();
    end
    directed("after_reset", 64'd40, 64'd2, 1'b0, 1'b0,
             '{s: 64'd42, cout: 1'b0, zf: 1'b0, sf: 1'b0, of: 1'b0});

    // Random traffic with random backpressure
    base = n_ret;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          send(rnd(), rnd(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");
    chk_int("rand_count", n_ret - base, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
